arbitro_vc: RTL and testbench

- Two-requester arbiter that shares the 6-bit VC output mux between the VC0 and VC1 FIFOs.
- Each cycle it decides which FIFO, if any, is popped. It then drives the mux selector one cycle later, aligned with the FIFO's registered read data.
- VC0 has strict priority, with a programmable starvation guard that forces a VC1 grant.
- Popping stops whenever the downstream almost-full flag is set.

---
 rtl/arbitro_vc.sv | 84 ++++++++
 tb/tb_arbitro_vc.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/arbitro_vc.sv
// VC0/VC1 output-mux arbiter: VC0 has priority, and a starvation counter forces a VC1 grant.
// The mux selector is registered so that it lines up with the FIFO's one-cycle read latency.
module arbitro_vc #(
  parameter int CNT_W          = 4,
  parameter int DEFAULT_WEIGHT = 3
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [CNT_W-1:0] weight_in,
  input  logic             fifo0_empty,
  input  logic             fifo1_empty,
  input  logic             down_almost_full,
  output logic             pop0,
  output logic             pop1,
  output logic             selector,
  output logic             sel_valid,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_INIT   = 2'd1,
    S_IDLE   = 2'd2,
    S_ACTIVE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEF_W = CNT_W'(DEFAULT_WEIGHT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic             selector_q, sel_valid_q;
  logic             pop0_c, pop1_c;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q     <= S_RESET;
      cnt_q       <= '0;
      limit_q     <= DEF_W;
      selector_q  <= 1'b0;
      sel_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      limit_q     <= limit_d;
      sel_valid_q <= pop0_c | pop1_c;
      if (pop0_c | pop1_c) selector_q <= pop1_c;
    end
  end

  always_comb begin
    state_d = state_q;
    pop0_c  = 1'b0;
    pop1_c  = 1'b0;
    limit_d = limit_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RESET: state_d = S_INIT;
      S_INIT: begin
        limit_d = (weight_in == '0) ? DEF_W : weight_in;
        state_d = S_IDLE;
      end
      S_IDLE: if (!fifo0_empty || !fifo1_empty) state_d = S_ACTIVE;
      S_ACTIVE: begin
        if (fifo0_empty && fifo1_empty) state_d = S_IDLE;
        if (!down_almost_full) begin
          // VC0 wins unless VC1 is waiting and has been passed over limit times
          if (!fifo0_empty && (fifo1_empty || cnt_q < limit_q)) pop0_c = 1'b1;
          else if (!fifo1_empty)                              pop1_c = 1'b1;
        end
        if (pop0_c && !fifo1_empty)    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        else if (pop1_c || fifo1_empty) cnt_d = '0;
      end
      default: state_d = S_RESET;
    endcase
  end

  assign pop0      = pop0_c;
  assign pop1      = pop1_c;
  assign selector  = selector_q;
  assign sel_valid = sel_valid_q;
  assign state     = state_q;

endmodule

// File: tb/tb_arbitro_vc.sv
// Bench for arbitro_vc: a FIFO-occupancy reference model drives the stimulus and predicts the pops,
// and a monitor pops the queued predictions to check the registered outputs one cycle later.
module tb_arbitro_vc;
  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic [3:0] weight_in = '0;
  logic       fifo0_empty = 1'b1, fifo1_empty = 1'b1, down_almost_full = 1'b0;
  logic       pop0, pop1, selector, sel_valid;
  logic [1:0] state;

  arbitro_vc #(.CNT_W(4), .DEFAULT_WEIGHT(3)) dut (
    .clk(clk), .reset_L(reset_L), .weight_in(weight_in),
    .fifo0_empty(fifo0_empty), .fifo1_empty(fifo1_empty),
    .down_almost_full(down_almost_full),
    .pop0(pop0), .pop1(pop1), .selector(selector), .sel_valid(sel_valid),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic sv; logic sel; logic [1:0] st; } exp_t;
  exp_t q[$];
  int   grants[$];
  int   total = 0, bad = 0;

  // Reference: FIFO occupancies plus phase/counter/limit kept as plain integers.
  int c0 = 0, c1 = 0;
  int m_state = 0, m_cnt = 0, m_limit = 3;
  bit m_sv = 0, m_sel = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input int add0, input int add1, input bit af,
                      input logic [3:0] w);
    bit e0, e1, p0, p1;
    int old_state;
    @(negedge clk);
    e0 = (c0 == 0);
    e1 = (c1 == 0);
    reset_L = rst; weight_in = w; down_almost_full = af;
    fifo0_empty = e0; fifo1_empty = e1;
    p0 = 0; p1 = 0;
    if (m_state == 3 && !af) begin
      if (!e0 && (e1 || m_cnt < m_limit)) p0 = 1;
      else if (!e1)                        p1 = 1;
    end
    #1;
    chk("pop0", int'(pop0 === 1'b1), int'(p0));
    chk("pop1", int'(pop1 === 1'b1), int'(p1));
    if (pop0 === 1'b1) grants.push_back(0);
    if (pop1 === 1'b1) grants.push_back(1);
    old_state = m_state;
    if (!rst) begin
      m_state = 0; m_cnt = 0; m_limit = 3; m_sv = 0; m_sel = 0;
    end else begin
      if (old_state == 3) begin
        if (p0 && !e1)      m_cnt = (m_cnt == 15) ? 15 : m_cnt + 1;
        else if (p1 || e1)  m_cnt = 0;
      end
      case (old_state)
        0: m_state = 1;
        1: begin m_limit = (w == 0) ? 3 : int'(w); m_state = 2; end
        2: if (!e0 || !e1) m_state = 3;
        default: if (e0 && e1) m_state = 2;
      endcase
      m_sv = p0 | p1;
      if (p0 | p1) m_sel = p1;
    end
    c0 = c0 - int'(p0) + add0;
    c1 = c1 - int'(p1) + add1;
    q.push_back('{sv: m_sv, sel: m_sel, st: 2'(m_state)});
  endtask

  task automatic restart(input logic [3:0] w);
    step(0, 0, 0, 0, w);
    step(0, 0, 0, 0, w);
    step(1, 0, 0, 0, w);
    step(1, 0, 0, 0, w);
  endtask

  task automatic check_seq(input string name, input int exp[$]);
    chk({name, "_len"}, grants.size(), exp.size());
    for (int i = 0; i < exp.size() && i < grants.size(); i++)
      chk(name, grants[i], exp[i]);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sel_valid", int'(sel_valid === 1'b1), int'(e.sv));
        chk("selector",  int'(selector === 1'b1),  int'(e.sel));
        chk("state",     int'(state),              int'(e.st));
      end
    end
  end

  initial begin
    int seq_a[$], seq_b[$];
    @(posedge clk);
    // Reset, INIT with the default weight, then IDLE
    restart(4'd0);
    step(1, 0, 0, 0, 0);
    // VC0-only burst of 4 words
    step(1, 4, 0, 0, 0);
    repeat (8) step(1, 0, 0, 0, 0);

    // Starvation guard at weight 2 with a 3-cycle backpressure stall mid-burst
    restart(4'd2);
    step(1, 6, 6, 0, 0);
    grants.delete();
    repeat (5) step(1, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 1, 0);
    repeat (12) step(1, 0, 0, 0, 0);
    seq_a = '{0,0,1,0,0,1,0,0,1,1,1,1};
    check_seq("seq_w2", seq_a);

    // Weight 1 gives strict alternation
    restart(4'd1);
    step(1, 4, 4, 0, 0);
    grants.delete();
    repeat (12) step(1, 0, 0, 0, 0);
    seq_b = '{0,1,0,1,0,1,0,1};
    check_seq("seq_w1", seq_b);

    // Reset dropped while VC1 is being popped
    step(1, 0, 3, 0, 0);
    step(1, 0, 0, 0, 0);
    grants.delete();
    step(0, 0, 0, 0, 0);
    chk("pop1_at_reset", grants.size(), 1);
    repeat (6) step(1, 0, 0, 0, 0);

    // Random traffic, backpressure, weights and occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
           ($urandom_range(0, 4) == 0),
           4'($urandom_range(0, 5)));
    end
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
